serial_subtractor: RTL

//   Bit-serial subtractor: computes DIFF = A - B - BIN over WIDTH cycles, LSB first.

---
 rtl/serial_subtractor_pkg.sv | 23 ++
 rtl/serial_subtractor_full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// +-------------------------------------------------------------------+
// | serial_subtractor_pkg: FSM state encodings and sizing helpers     |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_DONE2 = 2'd3
  } state_e;

  // Bit counter width: clog2(WIDTH), never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// +-------------------------------------------------------------------+
// | full_subtractor: one-bit combinational x - y - bin cell           |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +-------------------------------------------------------------------+
// | serial_subtractor: bit-serial a - b - bin, LSB first, WIDTH cycles |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   r_sh_q, r_sh_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cell_d;
  logic               cell_bo;
  logic [WIDTH-1:0]   r_next;

  full_subtractor u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // New difference bit enters at the MSB; written as shifts so WIDTH=1 works.
  assign r_next = (r_sh_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          r_sh_d   = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        r_sh_d   = r_next;
        borrow_d = cell_bo;
        if (cnt_q == CNT_LAST) begin
          diff_d  = r_next;
          bout_d  = cell_bo;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

`default_nettype wire
